mac_sequencer: RTL and testbench

- Sequences one shared sign-magnitude fixed-point multiplier (N-bit: MSB sign, N-1 fractional bits) over K input/weight pairs.
- Fetches each operand pair from external registered memories and accumulates the products in a wide two's-complement accumulator.
- Returns a saturated N-bit sign-magnitude dot product.
- Sits between the input/weight buffers and the neuron activation stage; one instance per neuron lane.

---
 rtl/mac_pkg.sv | 55 +++++
 rtl/sm_multiplier.sv | 29 ++
 rtl/mac_sequencer.sv | 139 +++++++++++++
 tb/tb_mac_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC sequencer slice.
//   - State encoding constants for the sequencer FSM (idle=0 .. done=4).
//   - sm_to_tc:     sign-magnitude (given width) -> two's complement, MaxW bits.
//   - tc_to_sm_sat: two's complement (MaxW bits, sign-extended) -> saturated
//                   sign-magnitude of a given width, plus an overflow flag.
// The helpers work on a fixed MaxW-bit carrier so that one definition serves any
// operand/accumulator width; callers slice the result down to their own width.
package mac_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StMul   = 3'd2;
  localparam logic [2:0] StAcc   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam int unsigned MaxW = 64;

  typedef struct packed {
    logic            ovf;
    logic [MaxW-1:0] sm;
  } sat_t;

  // Magnitude zero maps to +0 regardless of the sign bit.
  function automatic logic [MaxW-1:0] sm_to_tc(input logic [MaxW-1:0] sm,
                                               input int unsigned     width);
    logic [MaxW-1:0] mag_mask;
    logic [MaxW-1:0] mag;
    mag_mask = (MaxW'(1) << (width - 1)) - MaxW'(1);
    mag      = sm & mag_mask;
    return sm[width-1] ? (~mag + MaxW'(1)) : mag;
  endfunction

  // tc must already be sign-extended to MaxW bits.
  function automatic sat_t tc_to_sm_sat(input logic [MaxW-1:0] tc,
                                        input int unsigned     width);
    logic            neg;
    logic [MaxW-1:0] mag;
    logic [MaxW-1:0] max_mag;
    sat_t            r;
    neg     = tc[MaxW-1];
    mag     = neg ? (~tc + MaxW'(1)) : tc;
    max_mag = (MaxW'(1) << (width - 1)) - MaxW'(1);
    r.ovf   = (mag > max_mag);
    if (r.ovf) begin
      mag = max_mag;
    end
    r.sm = mag;
    // A negative value always has a nonzero magnitude, so no -0 can appear.
    if (neg) begin
      r.sm[width-1] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_multiplier.sv
// sm_multiplier: combinational N-bit sign-magnitude fixed-point multiplier.
// Operands and product use 1 sign bit + (N-1) fractional bits. The magnitude is
// the truncated upper half of the (N-1)x(N-1) product; a zero magnitude is
// always reported with sign 0.
// Ports:
//   a  input  N  multiplicand (sign-magnitude)
//   w  input  N  multiplier (sign-magnitude)
//   p  output N  product (sign-magnitude)
module sm_multiplier #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] w,
  output logic [N-1:0] p
);

  logic [2*N-3:0] full;
  logic [N-2:0]   mag;
  logic           sign;
  logic           unused_lo;

  assign full      = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, w[N-2:0]};
  // Dropping the low N-1 bits rescales the product back to N-1 fractional bits.
  assign mag       = full[2*N-3:N-1];
  assign unused_lo = ^full[N-2:0];
  assign sign      = (a[N-1] ^ w[N-1]) & (|mag);
  assign p         = {sign, mag};

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: time-multiplexes one sign-magnitude multiplier over K
// operand pairs read from registered external buffers, accumulates in a
// two's-complement accumulator and returns a saturated sign-magnitude result.
// Each term takes three cycles (fetch, multiply, accumulate) plus one final
// conversion cycle, so busy lasts 3K+1 cycles and done follows immediately.
// Ports:
//   clk       input  1   rising-edge clock
//   rst       input  1   asynchronous active-high reset
//   start     input  1   begin a dot product (ignored unless idle)
//   a_addr    output AW  input-buffer read address
//   w_addr    output AW  weight-buffer read address (mirrors a_addr)
//   a_data    input  N   input operand, valid one cycle after a_addr
//   w_data    input  N   weight operand, valid one cycle after w_addr
//   busy      output 1   sequencer active
//   done      output 1   one-cycle pulse, result valid
//   result    output N   sign-magnitude dot product, held until next done
//   overflow  output 1   result was saturated, held with result
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned K     = 4,
  parameter int unsigned AW    = (K > 1) ? $clog2(K) : 1,
  parameter int unsigned ACC_W = N + AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] w_addr,
  input  logic [N-1:0]  a_data,
  input  logic [N-1:0]  w_data,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          overflow
);

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic [N-1:0]     result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [N-1:0]     mul_p;
  logic [MaxW-1:0]  prod_ext;
  logic [MaxW-1:0]  acc_ext;
  sat_t             sat;
  logic             unused_hi;

  sm_multiplier #(
    .N (N)
  ) u_mul (
    .a (a_data),
    .w (w_data),
    .p (mul_p)
  );

  // Helper results are full carrier width; only the low bits are consumed.
  assign prod_ext  = sm_to_tc(MaxW'(mul_p), N);
  assign acc_ext   = {{(MaxW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign sat       = tc_to_sm_sat(acc_ext, N);
  assign unused_hi = ^{prod_ext[MaxW-1:ACC_W], sat.sm[MaxW-1:N]};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      StFetch: begin
        // Address is driven from idx_q; the buffers return data next cycle.
        state_d = StMul;
      end
      StMul: begin
        prod_d  = prod_ext[ACC_W-1:0];
        state_d = StAcc;
      end
      StAcc: begin
        acc_d = acc_q + prod_q;
        if (idx_q == AW'(K - 1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: begin
        result_d   = sat.sm[N-1:0];
        overflow_d = sat.ovf;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign a_addr   = idx_q;
  assign w_addr   = idx_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer (N=8, K=4). A behavioural dot-product
// model computes each expected result from the buffer contents with integer
// arithmetic; directed and random operations are compared against it.
module tb_mac_sequencer;

  localparam int N  = 8;
  localparam int K  = 4;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] w_addr;
  logic [N-1:0]  a_data;
  logic [N-1:0]  w_data;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic          overflow;

  logic [N-1:0] a_mem [K];
  logic [N-1:0] w_mem [K];

  int n_vec = 0;
  int n_err = 0;

  mac_sequencer #(
    .N (N),
    .K (K)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_addr   (a_addr),
    .w_addr   (w_addr),
    .a_data   (a_data),
    .w_data   (w_data),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered buffers: data appears one cycle after the address.
  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    w_data <= w_mem[w_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, result}.
  function automatic logic [N:0] model_dot();
    int   sum;
    int   m;
    int   mag;
    logic ov;
    logic s;
    sum = 0;
    for (int i = 0; i < K; i++) begin
      m = (int'(a_mem[i][N-2:0]) * int'(w_mem[i][N-2:0])) >> (N - 1);
      sum += (a_mem[i][N-1] ^ w_mem[i][N-1]) ? -m : m;
    end
    s   = (sum < 0);
    mag = s ? -sum : sum;
    ov  = (mag > (2 ** (N - 1)) - 1);
    if (ov) mag = (2 ** (N - 1)) - 1;
    return {ov, s, 7'(mag)};
  endfunction

  task automatic fill(input logic [N-1:0] a, input logic [N-1:0] w);
    for (int i = 0; i < K; i++) begin
      a_mem[i] = a;
      w_mem[i] = w;
    end
  endtask

  // Runs one operation starting in the current cycle and checks timing and
  // result. glitch_at > 0 raises start again that many cycles into the run.
  task automatic run_op(input string tag, input int glitch_at);
    logic [N:0] exp;
    int         busy_cnt;
    int         done_edge;
    exp       = model_dot();
    busy_cnt  = 0;
    done_edge = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_edge = cyc;
        start     = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
      start = (cyc == glitch_at);
    end
    start = 1'b0;
    check({tag, ".done_edge"}, done_edge, 3 * K + 1);
    check({tag, ".busy_cycles"}, busy_cnt, 3 * K + 1);
    check({tag, ".busy_at_done"}, int'(busy), 0);
    check({tag, ".result"}, int'(result), int'(exp[N-1:0]));
    check({tag, ".overflow"}, int'(overflow), int'(exp[N]));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  initial begin
    int extra_done;
    rst   = 1'b1;
    start = 1'b0;
    fill(8'h00, 8'h00);

    // Reset state
    idle_cycles(2);
    @(negedge clk);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.result", int'(result), 0);
    check("rst.overflow", int'(overflow), 0);
    check("rst.addr", int'(a_addr), 0);
    rst = 1'b0;
    idle_cycles(2);

    fill(8'h40, 8'h20);
    run_op("quarter", 0);
    idle_cycles(3);

    fill(8'h40, 8'h40);
    run_op("sat_pos", 0);
    idle_cycles(2);

    fill(8'h00, 8'h00);
    a_mem[0] = 8'h40; w_mem[0] = 8'h40;
    a_mem[1] = 8'hC0; w_mem[1] = 8'h40;
    run_op("cancel", 0);
    idle_cycles(2);

    fill(8'hC0, 8'h20);
    run_op("neg", 0);
    // Back-to-back: the next start lands in the done cycle.
    fill(8'h80, 8'h7F);
    run_op("negzero_b2b", 0);
    idle_cycles(2);

    fill(8'h00, 8'h00);
    a_mem[0] = 8'h7F; w_mem[0] = 8'h7F;
    run_op("trunc", 0);
    idle_cycles(2);

    // Restart attempt mid-operation must be dropped.
    fill(8'h40, 8'h20);
    a_mem[2] = 8'hFF; w_mem[2] = 8'h7F;
    run_op("glitch", 5);
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    check("glitch.no_second_op", extra_done, 0);

    // Asynchronous reset while in the multiply state.
    fill(8'h40, 8'h40);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.result", int'(result), 0);
    check("midrst.overflow", int'(overflow), 0);
    check("midrst.addr", int'(a_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);
    #1;
    check("midrst.stays_idle", int'(busy), 0);

    fill(8'hC0, 8'h20);
    run_op("after_rst", 0);
    idle_cycles(1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < K; i++) begin
        a_mem[i] = 8'($urandom_range(0, 255));
        w_mem[i] = 8'($urandom_range(0, 255));
      end
      run_op($sformatf("rand%0d", r), 0);
      if (r[0]) idle_cycles(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
